hud_sprite_rom_arbiter: RTL and testbench

- Shares one single-port synchronous sprite ROM (the 35x24 HUD heart image, 9-bit pixels) among N_REQ pixel requesters, e.g. the life-heart generator, the score-digit generator and the pause banner.
- Round-robin arbitration, one ROM access per clk_25MHz cycle.
- Each response is tagged back to its requester after the fixed ROM latency.
- Sits between the HUD pixel generators and the ROM instance; the ROM's write port is tied off.

---
 rtl/hud_sprite_rom_arbiter_if.sv | 26 ++
 rtl/hud_sprite_rom_arbiter.sv | 82 ++++++++
 tb/tb_hud_sprite_rom_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hud_sprite_rom_arbiter_if.sv
// Request/response bundle between the HUD pixel generators, the shared sprite ROM and the arbiter.
// The arbiter takes the slave side; requesters plus the ROM instance sit on the master side.
interface hud_sprite_rom_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 9
) ();
    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]       rom_addr;
    logic [DATA_W-1:0]       rom_dout;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_data;
    logic                    busy;

    modport master (
        output req, req_addr, rom_dout,
        input  gnt, rom_addr, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req, req_addr, rom_dout,
        output gnt, rom_addr, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/hud_sprite_rom_arbiter.sv
// Round-robin sharing of the single-port HUD sprite ROM among N_REQ pixel requesters,
// with each ROM word tagged back to its requester after the fixed ROM read latency.
module hud_sprite_rom_arbiter #(
    parameter int N_REQ   = 3,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 9,
    parameter int ROM_LAT = 1
) (
    input  logic                    clk_25MHz,
    input  logic                    rst,
    hud_sprite_rom_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic [IDX_W:0]     scan_idx;
    logic [N_REQ-1:0]   gnt_c;
    logic [ADDR_W-1:0]  rom_addr_q;
    logic [ROM_LAT-1:0] tag_v;
    logic [IDX_W-1:0]   tag_idx [ROM_LAT];
    logic [N_REQ-1:0]   rsp_valid_q;
    logic [DATA_W-1:0]  rsp_data_c;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        gnt_c     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (scan_idx >= (IDX_W+1)'(N_REQ))
                scan_idx = scan_idx - (IDX_W+1)'(N_REQ);
            if (!win_found && bus.req[scan_idx[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_idx[IDX_W-1:0];
            end
        end
        if (!rst)
            win_found = 1'b0;
        if (win_found)
            gnt_c[win_idx] = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_25MHz) begin
        if (!rst) begin
            rr_ptr      <= '0;
            rom_addr_q  <= '0;
            tag_v       <= '0;
            rsp_valid_q <= '0;
        end else begin
            if (win_found) begin
                rr_ptr     <= (win_idx == IDX_W'(N_REQ-1)) ? '0 : win_idx + 1'b1;
                rom_addr_q <= bus.req_addr[win_idx*ADDR_W +: ADDR_W];
            end
            tag_v[0] <= win_found;
            for (int s = 1; s < ROM_LAT; s++)
                tag_v[s] <= tag_v[s-1];
            // The response register lines the tag up with the ROM's registered output word.
            rsp_valid_q <= '0;
            if (tag_v[ROM_LAT-1])
                rsp_valid_q[tag_idx[ROM_LAT-1]] <= 1'b1;
        end
    end

    // NOTE: the index payload is not reset; it is only ever read when its valid bit is set.
    always_ff @(posedge clk_25MHz) begin
        tag_idx[0] <= win_idx;
        for (int s = 1; s < ROM_LAT; s++)
            tag_idx[s] <= tag_idx[s-1];
    end

    assign rsp_data_c    = bus.rom_dout;
    assign bus.gnt       = gnt_c;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_c;
    assign bus.busy      = |tag_v;
endmodule

// File: tb/tb_hud_sprite_rom_arbiter.sv
// Bench for hud_sprite_rom_arbiter: randomized and directed traffic on a ROM_LAT=1 instance
// against a transaction-level model, plus directed latency/reset scenarios at ROM_LAT=3 and 2.
module tb_hud_sprite_rom_arbiter;
    logic clk = 1'b0;
    logic rst1 = 1'b0, rst2 = 1'b0, rst3 = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hud_sprite_rom_arbiter_if #(.N_REQ(3), .ADDR_W(10), .DATA_W(9)) b1 ();
    hud_sprite_rom_arbiter_if #(.N_REQ(3), .ADDR_W(10), .DATA_W(9)) b2 ();
    hud_sprite_rom_arbiter_if #(.N_REQ(3), .ADDR_W(10), .DATA_W(9)) b3 ();

    hud_sprite_rom_arbiter #(.N_REQ(3), .ADDR_W(10), .DATA_W(9), .ROM_LAT(1))
        u_lat1 (.clk_25MHz(clk), .rst(rst1), .bus(b1.slave));
    hud_sprite_rom_arbiter #(.N_REQ(3), .ADDR_W(10), .DATA_W(9), .ROM_LAT(2))
        u_lat2 (.clk_25MHz(clk), .rst(rst2), .bus(b2.slave));
    hud_sprite_rom_arbiter #(.N_REQ(3), .ADDR_W(10), .DATA_W(9), .ROM_LAT(3))
        u_lat3 (.clk_25MHz(clk), .rst(rst3), .bus(b3.slave));

    // Sprite ROM contents: an arbitrary but deterministic word per address.
    function automatic logic [8:0] rom_fn(input logic [9:0] a);
        logic [19:0] t;
        t = {10'd0, a} * 20'd5 + 20'd17;
        return t[8:0] ^ {3'b000, a[9:4]};
    endfunction

    // Synchronous ROM models with read latency 1, 2 and 3.
    logic [8:0] r1_d, r2_d [2], r3_d [3];
    always @(posedge clk) begin
        r1_d    <= rom_fn(b1.rom_addr);
        r2_d[0] <= rom_fn(b2.rom_addr);
        r2_d[1] <= r2_d[0];
        r3_d[0] <= rom_fn(b3.rom_addr);
        r3_d[1] <= r3_d[0];
        r3_d[2] <= r3_d[1];
    end
    assign b1.rom_dout = r1_d;
    assign b2.rom_dout = r2_d[1];
    assign b3.rom_dout = r3_d[2];

    // Transaction-level reference for the ROM_LAT=1 instance.
    localparam int L1 = 1;
    typedef struct {
        bit         v;
        int         idx;
        logic [9:0] addr;
    } ent_t;
    ent_t       hist [$];
    int         m_ptr;
    logic [9:0] m_addr;

    task automatic model_reset1();
        ent_t e;
        e.v = 1'b0; e.idx = 0; e.addr = '0;
        hist.delete();
        for (int i = 0; i <= L1; i++) hist.push_back(e);
        m_ptr  = 0;
        m_addr = '0;
    endtask

    // One clock cycle on instance 1: drive, check grant, let the edge happen, check outputs.
    task automatic step1(input logic [2:0] r, input logic [9:0] a0, a1, a2, input string name,
                         output logic [2:0] g_seen, output logic [9:0] addr_seen);
        int         w;
        logic [2:0] exp_gnt, exp_rsp;
        logic       exp_busy;
        ent_t       e;
        @(negedge clk);
        b1.req      = r;
        b1.req_addr = {a2, a1, a0};
        #1;
        w = -1;
        for (int k = 0; k < 3; k++)
            if (w < 0 && r[(m_ptr + k) % 3]) w = (m_ptr + k) % 3;
        exp_gnt = (w < 0) ? 3'b000 : 3'(1 << w);
        g_seen  = b1.gnt;
        checks++;
        if (b1.gnt !== exp_gnt) begin
            failures++;
            $display("FAIL %s gnt: got %b expected %b", name, b1.gnt, exp_gnt);
        end
        @(posedge clk);
        e.v = (w >= 0); e.idx = (w < 0) ? 0 : w; e.addr = '0;
        if (w >= 0) begin
            m_ptr  = (w + 1) % 3;
            m_addr = (w == 0) ? a0 : (w == 1) ? a1 : a2;
            e.addr = m_addr;
        end
        hist.push_back(e);
        if (hist.size() > L1 + 1) void'(hist.pop_front());
        exp_rsp  = hist[0].v ? 3'(1 << hist[0].idx) : 3'b000;
        exp_busy = 1'b0;
        for (int i = 1; i <= L1; i++) exp_busy |= hist[i].v;
        #1;
        addr_seen = b1.rom_addr;
        checks++;
        if (b1.rom_addr !== m_addr) begin
            failures++;
            $display("FAIL %s rom_addr: got %0d expected %0d", name, b1.rom_addr, m_addr);
        end
        checks++;
        if (b1.rsp_valid !== exp_rsp) begin
            failures++;
            $display("FAIL %s rsp_valid: got %b expected %b", name, b1.rsp_valid, exp_rsp);
        end
        if (hist[0].v) begin
            checks++;
            if (b1.rsp_data !== rom_fn(hist[0].addr)) begin
                failures++;
                $display("FAIL %s rsp_data: got %0d expected %0d", name, b1.rsp_data,
                         rom_fn(hist[0].addr));
            end
        end
        checks++;
        if (b1.busy !== exp_busy) begin
            failures++;
            $display("FAIL %s busy: got %b expected %b", name, b1.busy, exp_busy);
        end
    endtask

    // Hold instance 1 in reset for n cycles with every request raised.
    task automatic do_reset1(input int n, input string name);
        @(negedge clk);
        rst1        = 1'b0;
        b1.req      = 3'b111;
        b1.req_addr = {10'd3, 10'd2, 10'd1};
        for (int i = 0; i < n; i++) begin
            #1;
            checks++;
            if (b1.gnt !== 3'b000) begin
                failures++;
                $display("FAIL %s gnt in reset: got %b expected 000", name, b1.gnt);
            end
            @(posedge clk);
            #1;
            checks++;
            if (b1.rsp_valid !== 3'b000 || b1.rom_addr !== 10'd0 || b1.busy !== 1'b0) begin
                failures++;
                $display("FAIL %s reset state: rsp_valid=%b rom_addr=%0d busy=%b expected 000/0/0",
                         name, b1.rsp_valid, b1.rom_addr, b1.busy);
            end
        end
        rst1 = 1'b1;
        model_reset1();
    endtask

    task automatic test_reset();
        logic [2:0] g;
        logic [9:0] a;
        do_reset1(3, "reset");
        step1(3'b111, 10'd1, 10'd2, 10'd3, "reset_release", g, a);
        checks++;
        if (g !== 3'b001) begin
            failures++;
            $display("FAIL reset_first_grant: got %b expected 001", g);
        end
        step1(3'b000, 10'd0, 10'd0, 10'd0, "reset_drain", g, a);
    endtask

    task automatic test_single();
        logic [2:0] g;
        logic [9:0] a;
        step1(3'b010, 10'd0, 10'd37, 10'd0, "single_req", g, a);
        checks++;
        if (g !== 3'b010 || a !== 10'd37) begin
            failures++;
            $display("FAIL single_grant: got gnt=%b addr=%0d expected 010/37", g, a);
        end
        step1(3'b000, 10'd0, 10'd0, 10'd0, "single_rsp", g, a);
        step1(3'b000, 10'd0, 10'd0, 10'd0, "single_idle", g, a);
    endtask

    task automatic test_contention();
        logic [2:0] g;
        logic [9:0] a;
        logic [2:0] exp_g [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        logic [9:0] exp_a [6] = '{10'd10, 10'd20, 10'd30, 10'd10, 10'd20, 10'd30};
        do_reset1(1, "contention");
        for (int i = 0; i < 6; i++) begin
            step1(3'b111, 10'd10, 10'd20, 10'd30, "contention", g, a);
            checks++;
            if (g !== exp_g[i] || a !== exp_a[i]) begin
                failures++;
                $display("FAIL contention_seq[%0d]: got gnt=%b addr=%0d expected %b/%0d",
                         i, g, a, exp_g[i], exp_a[i]);
            end
        end
        repeat (2) step1(3'b000, 10'd0, 10'd0, 10'd0, "contention_drain", g, a);
    endtask

    task automatic test_pointer_persist();
        logic [2:0] g;
        logic [9:0] a;
        step1(3'b100, 10'd0, 10'd0, 10'd500, "persist_g2", g, a);
        repeat (5) step1(3'b000, 10'd0, 10'd0, 10'd0, "persist_idle", g, a);
        step1(3'b101, 10'd7, 10'd0, 10'd9, "persist_first", g, a);
        checks++;
        if (g !== 3'b001) begin
            failures++;
            $display("FAIL persist_first: got %b expected 001", g);
        end
        step1(3'b101, 10'd7, 10'd0, 10'd9, "persist_second", g, a);
        checks++;
        if (g !== 3'b100) begin
            failures++;
            $display("FAIL persist_second: got %b expected 100", g);
        end
        repeat (2) step1(3'b000, 10'd0, 10'd0, 10'd0, "persist_drain", g, a);
    endtask

    task automatic test_back_to_back();
        logic [2:0] g;
        logic [9:0] a;
        for (int i = 0; i < 4; i++) begin
            step1(3'b010, 10'd0, 10'(900 + i), 10'd0, "b2b_single", g, a);
            checks++;
            if (g !== 3'b010) begin
                failures++;
                $display("FAIL b2b_single[%0d]: got %b expected 010", i, g);
            end
        end
        step1(3'b000, 10'd0, 10'd0, 10'd0, "b2b_drain", g, a);
    endtask

    task automatic test_random();
        logic [2:0] g;
        logic [9:0] a, a0, a1, a2;
        for (int i = 0; i < 300; i++) begin
            a0 = 10'($urandom_range(0, 1023));
            a1 = 10'($urandom_range(0, 1023));
            a2 = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(840, 1023))
                                              : 10'($urandom_range(0, 839));
            if (i == 150) do_reset1(1, "random_reset");
            step1(3'($urandom_range(0, 7)), a0, a1, a2, "random", g, a);
        end
        repeat (2) step1(3'b000, 10'd0, 10'd0, 10'd0, "random_drain", g, a);
    endtask

    task automatic test_latency3();
        logic [2:0] exp_r;
        @(negedge clk);
        b3.req = 3'b010; b3.req_addr = {10'd0, 10'd100, 10'd0};
        #1;
        checks++;
        if (b3.gnt !== 3'b010) begin
            failures++;
            $display("FAIL lat3_gnt1: got %b expected 010", b3.gnt);
        end
        @(posedge clk); #1;
        checks++;
        if (b3.rom_addr !== 10'd100 || b3.rsp_valid !== 3'b000 || b3.busy !== 1'b1) begin
            failures++;
            $display("FAIL lat3_edge0: addr=%0d rsp=%b busy=%b expected 100/000/1",
                     b3.rom_addr, b3.rsp_valid, b3.busy);
        end
        @(negedge clk);
        b3.req = 3'b001; b3.req_addr = {10'd0, 10'd0, 10'd200};
        #1;
        checks++;
        if (b3.gnt !== 3'b001) begin
            failures++;
            $display("FAIL lat3_gnt2: got %b expected 001", b3.gnt);
        end
        @(posedge clk); #1;
        checks++;
        if (b3.rom_addr !== 10'd200 || b3.rsp_valid !== 3'b000) begin
            failures++;
            $display("FAIL lat3_edge1: addr=%0d rsp=%b expected 200/000", b3.rom_addr, b3.rsp_valid);
        end
        @(negedge clk);
        b3.req = 3'b000;
        for (int n = 2; n <= 7; n++) begin
            @(posedge clk); #1;
            exp_r = (n == 3) ? 3'b010 : (n == 4) ? 3'b001 : 3'b000;
            checks++;
            if (b3.rsp_valid !== exp_r || b3.busy !== (n <= 3)) begin
                failures++;
                $display("FAIL lat3_edge%0d: rsp=%b busy=%b expected %b/%b",
                         n, b3.rsp_valid, b3.busy, exp_r, (n <= 3));
            end
            if (n == 3 || n == 4) begin
                checks++;
                if (b3.rsp_data !== rom_fn((n == 3) ? 10'd100 : 10'd200)) begin
                    failures++;
                    $display("FAIL lat3_data%0d: got %0d expected %0d", n, b3.rsp_data,
                             rom_fn((n == 3) ? 10'd100 : 10'd200));
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        b2.req = 3'b001; b2.req_addr = {10'd0, 10'd0, 10'd5};
        #1;
        checks++;
        if (b2.gnt !== 3'b001) begin
            failures++;
            $display("FAIL midflight_gnt1: got %b expected 001", b2.gnt);
        end
        @(posedge clk);
        @(negedge clk);
        b2.req = 3'b010; b2.req_addr = {10'd0, 10'd6, 10'd0};
        @(posedge clk); #1;
        checks++;
        if (b2.busy !== 1'b1 || b2.rsp_valid !== 3'b000 || b2.rom_addr !== 10'd6) begin
            failures++;
            $display("FAIL midflight_inflight: busy=%b rsp=%b addr=%0d expected 1/000/6",
                     b2.busy, b2.rsp_valid, b2.rom_addr);
        end
        @(negedge clk);
        rst2 = 1'b0; b2.req = 3'b000;
        for (int n = 0; n < 8; n++) begin
            if (n == 3) begin
                @(negedge clk);
                rst2 = 1'b1;
            end
            @(posedge clk); #1;
            checks++;
            if (b2.rsp_valid !== 3'b000 || b2.busy !== 1'b0) begin
                failures++;
                $display("FAIL midflight_after[%0d]: rsp=%b busy=%b expected 000/0",
                         n, b2.rsp_valid, b2.busy);
            end
        end
    endtask

    initial begin
        b1.req = '0; b1.req_addr = '0;
        b2.req = '0; b2.req_addr = '0;
        b3.req = '0; b3.req_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst2 = 1'b1;
        rst3 = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_pointer_persist();
        test_back_to_back();
        test_random();
        test_latency3();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
